bht_counter_table: RTL and testbench
====================================

// Module: bht_counter_table
// PURPOSE
//   Parametrised branch history table: DEPTH saturating counters with a predict port, a resolve/update
//   port and optional gshare indexing. Replaces the fixed 256x2 dual-port bht macro in the fetch
//   path. Adds a self-clearing reset sweep, in-block saturating read-modify-write and write-to-predict
//   bypass. Fetch drives predict; branch resolution in the backend drives update.
// PARAMETERS
//   INDEX_WIDTH  8  table index bits; DEPTH = 1<<INDEX_WIDTH
//   CTR_WIDTH    2  counter width, >=2; prediction = counter MSB
//   INIT_VALUE   1  value written to every entry by the reset sweep (weakly not-taken for 2 bits)
//   USE_GSHARE   0  1: index = pc[INDEX_WIDTH+1:2] ^ zero-extended ghr; 0: index = pc[INDEX_WIDTH+1:2]
//   GHR_WIDTH    8  global history bits, 1..INDEX_WIDTH; ignored when USE_GSHARE=0
// PORTS
//   clk         in   1            clock
//   rst         in   1            synchronous reset, active high
//   ready       out  1            1 = sweep done, ports live
//   pred_req    in   1            predict request this cycle
//   pred_pc     in   32           fetch PC
//   pred_valid  out  1            result valid (one cycle after pred_req)
//   pred_taken  out  1            predicted direction
//   pred_ctr    out  CTR_WIDTH    counter value used
//   pred_idx    out  INDEX_WIDTH  index used; fetch carries it to resolution
//   upd_valid   in   1            branch resolved this cycle
//   upd_idx     in   INDEX_WIDTH  index returned from pred_idx
//   upd_taken   in   1            actual direction
//   ghr         out  GHR_WIDTH    current global history (0 when USE_GSHARE=0)
// BEHAVIOUR
//   Reset (any edge with rst=1): ready=0, pred_valid=0, pred_taken=0, pred_ctr=0, pred_idx=0, ghr=0,
//     pending update dropped, state=INIT, sweep pointer=0. Reset mid-sweep restarts at 0.
//   INIT: each edge with rst=0 writes INIT_VALUE to mem[sweep]; pointer+1. Edge writing DEPTH-1 ->
//     RUN, ready=1. ready rises exactly DEPTH edges after rst deasserts. pred_req and upd_valid
//     ignored in INIT (pred_valid stays 0, nothing queued, ghr unchanged).
//   RUN: no return to INIT except via rst.
//   Update pipeline (RUN): upd_valid sampled at edge E -> U1 regs {idx,taken}. Next cycle:
//     new = taken ? (ctr==max ? max : ctr+1) : (ctr==0 ? 0 : ctr-1), ctr = mem[U1.idx];
//     written at E+1. ghr <= {ghr[GHR_WIDTH-2:0], taken} at E+1 when USE_GSHARE=1.
//     One update accepted per cycle; back-to-back updates to same index chain correctly
//     (each U1 read sees previous write). No backpressure.
//   Predict (RUN): pred_req sampled at edge P with idx computed from pred_pc and ghr at P.
//     Registered at P: pred_valid=1, pred_idx=idx, pred_ctr=(U1 valid && U1.idx==idx) ? new : mem[idx],
//     pred_taken=pred_ctr[CTR_WIDTH-1]. Latency 1; outputs held until next sampled edge;
//     pred_valid=0 after an edge with pred_req=0.
//   Simultaneous predict and update to same index in same cycle: predict sees pre-update value
//     (update not in U1 yet). Predict in the cycle the write commits: bypass gives new value.
//   ghr used for indexing is the value before the shift committing at the same edge.
//   pc[1:0] and pc bits above INDEX_WIDTH+1 unused.
//   Storage: reg array, 1 write/cycle (sweep or update, never both), combinational read.
// TESTING
//   Reset sweep: rst 1 cycle, defaults -> ready=0 for 256 edges then 1; predict pc 0x0..0x3FC ->
//     every pred_ctr=1, pred_taken=0.
//   Saturation: 3 taken updates idx 5 -> predict pc 0x14: ctr 3, taken=1; 4 not-taken -> ctr 0, taken=0.
//   Bypass: upd idx 7 taken sampled E, predict pc 0x1C sampled E+1 -> pred_ctr=2; sampled E -> pred_ctr=1.
//   Reset mid-sweep: rst at sweep edge 100 -> ready rises 256 edges after rst low; predict shows INIT_VALUE everywhere.
//   Gshare (USE_GSHARE=1, GHR_WIDTH=8): updates taken,taken -> ghr=0x03; predict pc 0x14 -> pred_idx=0x06.
//   INIT ignore: upd_valid/pred_req during sweep -> pred_valid=0, ghr=0, counters all INIT_VALUE.

Source files
------------

// File: rtl/bht_counter_table.sv
// Branch history table of saturating counters with predict and resolve ports, optional gshare
// indexing, a self-clearing reset sweep and a bypass from the pending update to the predict read.
module bht_counter_table #(
   parameter int INDEX_WIDTH = 8,
   parameter int CTR_WIDTH   = 2,
   parameter int INIT_VALUE  = 1,
   parameter int USE_GSHARE  = 0,
   parameter int GHR_WIDTH   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   ready,
   input  logic                   pred_req,
   input  logic [31:0]            pred_pc,
   output logic                   pred_valid,
   output logic                   pred_taken,
   output logic [CTR_WIDTH-1:0]   pred_ctr,
   output logic [INDEX_WIDTH-1:0] pred_idx,
   input  logic                   upd_valid,
   input  logic [INDEX_WIDTH-1:0] upd_idx,
   input  logic                   upd_taken,
   output logic [GHR_WIDTH-1:0]   ghr
);

   localparam int DEPTH = 1 << INDEX_WIDTH;
   localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
   localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(INIT_VALUE);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e                 state_q, state_d;
   logic [INDEX_WIDTH-1:0] sweep_q, sweep_d;
   logic                   u1_valid_q, u1_valid_d;
   logic [INDEX_WIDTH-1:0] u1_idx_q, u1_idx_d;
   logic                   u1_taken_q, u1_taken_d;
   logic [GHR_WIDTH-1:0]   ghr_q, ghr_d;
   logic                   pred_valid_q, pred_valid_d;
   logic [CTR_WIDTH-1:0]   pred_ctr_q, pred_ctr_d;
   logic [INDEX_WIDTH-1:0] pred_idx_q, pred_idx_d;

   logic [CTR_WIDTH-1:0]   mem_q [DEPTH];

   logic [CTR_WIDTH-1:0]   u1_ctr, u1_new, pred_ctr_c;
   logic [INDEX_WIDTH-1:0] ghr_ext, pred_idx_c;
   logic                   wr_en;
   logic [INDEX_WIDTH-1:0] wr_idx;
   logic [CTR_WIDTH-1:0]   wr_data;
   logic                   unused_pc_bits;

   assign unused_pc_bits = ^{pred_pc[31:INDEX_WIDTH+2], pred_pc[1:0]};

   // Saturating read-modify-write for the update sitting in U1.
   assign u1_ctr = mem_q[u1_idx_q];
   assign u1_new = u1_taken_q ? ((u1_ctr == CTR_MAX) ? CTR_MAX : u1_ctr + 1'b1)
                              : ((u1_ctr == '0) ? '0 : u1_ctr - 1'b1);

   assign ghr_ext    = INDEX_WIDTH'(ghr_q);
   assign pred_idx_c = (USE_GSHARE != 0) ? (pred_pc[INDEX_WIDTH+1:2] ^ ghr_ext)
                                         : pred_pc[INDEX_WIDTH+1:2];
   // A write committing this edge is not in the array yet, so forward it.
   assign pred_ctr_c = (u1_valid_q && (u1_idx_q == pred_idx_c)) ? u1_new : mem_q[pred_idx_c];

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      state_d      = state_q;
      sweep_d      = sweep_q;
      u1_valid_d   = 1'b0;
      u1_idx_d     = u1_idx_q;
      u1_taken_d   = u1_taken_q;
      ghr_d        = ghr_q;
      pred_valid_d = 1'b0;
      pred_ctr_d   = pred_ctr_q;
      pred_idx_d   = pred_idx_q;
      wr_en        = 1'b0;
      wr_idx       = sweep_q;
      wr_data      = CTR_INIT;

      if (state_q == ST_INIT) begin
         wr_en   = 1'b1;
         sweep_d = sweep_q + 1'b1;
         if (sweep_q == '1) state_d = ST_RUN;
      end else begin
         if (upd_valid) begin
            u1_valid_d = 1'b1;
            u1_idx_d   = upd_idx;
            u1_taken_d = upd_taken;
         end
         if (u1_valid_q) begin
            wr_en   = 1'b1;
            wr_idx  = u1_idx_q;
            wr_data = u1_new;
            if (USE_GSHARE != 0) ghr_d = (ghr_q << 1) | GHR_WIDTH'(u1_taken_q);
         end
         if (pred_req) begin
            pred_valid_d = 1'b1;
            pred_idx_d   = pred_idx_c;
            pred_ctr_d   = pred_ctr_c;
         end
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_INIT;
         sweep_q      <= '0;
         u1_valid_q   <= 1'b0;
         u1_idx_q     <= '0;
         u1_taken_q   <= 1'b0;
         ghr_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_ctr_q   <= '0;
         pred_idx_q   <= '0;
      end else begin
         state_q      <= state_d;
         sweep_q      <= sweep_d;
         u1_valid_q   <= u1_valid_d;
         u1_idx_q     <= u1_idx_d;
         u1_taken_q   <= u1_taken_d;
         ghr_q        <= ghr_d;
         pred_valid_q <= pred_valid_d;
         pred_ctr_q   <= pred_ctr_d;
         pred_idx_q   <= pred_idx_d;
      end
   end

   // NOTE: the counter array has no reset branch; the INIT sweep clears it, keeping it a plain
   // register file.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= wr_data;
   end

   assign ready      = (state_q == ST_RUN);
   assign pred_valid = pred_valid_q;
   assign pred_ctr   = pred_ctr_q;
   assign pred_taken = pred_ctr_q[CTR_WIDTH-1];
   assign pred_idx   = pred_idx_q;
   assign ghr        = ghr_q;

endmodule

// File: tb/tb_bht_counter_table.sv
// Directed bench for bht_counter_table: a bimodal instance and a gshare instance share clock
// and reset; predictions are scored against a queue of expected results.
module tb_bht_counter_table;

   typedef struct {
      string      tag;
      logic [1:0] ctr;
      logic [7:0] idx;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   logic        m_ready, m_pred_req, m_pred_valid, m_pred_taken, m_upd_valid, m_upd_taken;
   logic [31:0] m_pred_pc;
   logic [1:0]  m_pred_ctr;
   logic [7:0]  m_pred_idx, m_upd_idx, m_ghr;

   logic        g_ready, g_pred_req, g_pred_valid, g_pred_taken, g_upd_valid, g_upd_taken;
   logic [31:0] g_pred_pc;
   logic [1:0]  g_pred_ctr;
   logic [7:0]  g_pred_idx, g_upd_idx, g_ghr;

   exp_t m_q[$];
   exp_t g_q[$];
   int   errors = 0;
   int   checks = 0;
   int   n;

   always #5 clk = ~clk;

   bht_counter_table u_bimodal (
      .clk(clk), .rst(rst), .ready(m_ready),
      .pred_req(m_pred_req), .pred_pc(m_pred_pc), .pred_valid(m_pred_valid),
      .pred_taken(m_pred_taken), .pred_ctr(m_pred_ctr), .pred_idx(m_pred_idx),
      .upd_valid(m_upd_valid), .upd_idx(m_upd_idx), .upd_taken(m_upd_taken), .ghr(m_ghr)
   );

   bht_counter_table #(.USE_GSHARE(1), .GHR_WIDTH(8)) u_gshare (
      .clk(clk), .rst(rst), .ready(g_ready),
      .pred_req(g_pred_req), .pred_pc(g_pred_pc), .pred_valid(g_pred_valid),
      .pred_taken(g_pred_taken), .pred_ctr(g_pred_ctr), .pred_idx(g_pred_idx),
      .upd_valid(g_upd_valid), .upd_idx(g_upd_idx), .upd_taken(g_upd_taken), .ghr(g_ghr)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      m_pred_req = 1'b0; m_pred_pc = '0; m_upd_valid = 1'b0; m_upd_idx = '0; m_upd_taken = 1'b0;
      g_pred_req = 1'b0; g_pred_pc = '0; g_upd_valid = 1'b0; g_upd_idx = '0; g_upd_taken = 1'b0;
   endtask

   task automatic pred_m(input string tag, input logic [31:0] pc, input logic [1:0] ctr,
                         input logic [7:0] idx);
      exp_t e;
      m_pred_req = 1'b1; m_pred_pc = pc;
      e.tag = tag; e.ctr = ctr; e.idx = idx;
      m_q.push_back(e);
   endtask

   task automatic pred_g(input string tag, input logic [31:0] pc, input logic [1:0] ctr,
                         input logic [7:0] idx);
      exp_t e;
      g_pred_req = 1'b1; g_pred_pc = pc;
      e.tag = tag; e.ctr = ctr; e.idx = idx;
      g_q.push_back(e);
   endtask

   task automatic upd_m(input logic [7:0] idx, input logic taken);
      m_upd_valid = 1'b1; m_upd_idx = idx; m_upd_taken = taken;
   endtask

   task automatic upd_g(input logic [7:0] idx, input logic taken);
      g_upd_valid = 1'b1; g_upd_idx = idx; g_upd_taken = taken;
   endtask

   // Requests aimed at a table still sweeping; no expectation is queued for them.
   task automatic poke(input int i);
      upd_m(8'(i), 1'b1); upd_g(8'(i), 1'b1);
      m_pred_req = 1'b1; m_pred_pc = 32'(i) << 2;
      g_pred_req = 1'b1; g_pred_pc = 32'(i) << 2;
   endtask

   // One clock: outputs are sampled 1 time unit after the edge, then inputs return to idle.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (m_q.size() > 0) begin
         e = m_q.pop_front();
         check({e.tag, "/m_valid"}, m_pred_valid, 1);
         check({e.tag, "/m_ctr"}, m_pred_ctr, e.ctr);
         check({e.tag, "/m_taken"}, m_pred_taken, e.ctr[1]);
         check({e.tag, "/m_idx"}, m_pred_idx, e.idx);
      end else begin
         check("m_idle_valid", m_pred_valid, 0);
      end
      if (g_q.size() > 0) begin
         e = g_q.pop_front();
         check({e.tag, "/g_valid"}, g_pred_valid, 1);
         check({e.tag, "/g_ctr"}, g_pred_ctr, e.ctr);
         check({e.tag, "/g_taken"}, g_pred_taken, e.ctr[1]);
         check({e.tag, "/g_idx"}, g_pred_idx, e.idx);
      end else begin
         check("g_idle_valid", g_pred_valid, 0);
      end
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      tick();
      check("rst_m_ready", m_ready, 0);
      check("rst_m_taken", m_pred_taken, 0);
      check("rst_m_ctr", m_pred_ctr, 0);
      check("rst_m_idx", m_pred_idx, 0);
      check("rst_m_ghr", m_ghr, 0);
      check("rst_g_ready", g_ready, 0);
      check("rst_g_ghr", g_ghr, 0);

      // First sweep interrupted at edge 100, with requests poked in along the way.
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (i >= 40 && i < 50) poke(i);
         tick();
      end
      check("mid_sweep_ready", m_ready, 0);
      rst = 1'b1;
      tick();
      check("restart_ready", m_ready, 0);
      rst = 1'b0;

      n = 0;
      for (int i = 0; i < 300 && !m_ready; i++) begin
         if (i >= 60 && i < 70) poke(i);
         tick();
         n++;
      end
      check("sweep_edges", n, 256);
      check("g_ready_after_sweep", g_ready, 1);
      check("init_m_ghr", m_ghr, 0);
      check("init_g_ghr", g_ghr, 0);

      for (int i = 0; i < 256; i++) begin
         pred_m("sweep", 32'(i) << 2, 2'd1, 8'(i));
         pred_g("sweep", 32'(i) << 2, 2'd1, 8'(i));
         tick();
      end

      // Saturation on index 5: 1 -> 2 -> 3 -> 3, then down to 0 and held.
      for (int k = 0; k < 3; k++) begin
         upd_m(8'd5, 1'b1);
         tick();
      end
      tick();
      pred_m("sat_up", 32'h14, 2'd3, 8'd5);
      tick();
      for (int k = 0; k < 4; k++) begin
         upd_m(8'd5, 1'b0);
         tick();
      end
      tick();
      pred_m("sat_down", 32'h14, 2'd0, 8'd5);
      tick();

      // Bypass on index 7.
      upd_m(8'd7, 1'b1);
      pred_m("byp_same_edge", 32'h1C, 2'd1, 8'd7);
      tick();
      pred_m("byp_next_edge", 32'h1C, 2'd2, 8'd7);
      tick();
      pred_m("byp_committed", 32'h1C, 2'd2, 8'd7);
      tick();
      upd_m(8'd7, 1'b0);
      tick();
      upd_m(8'd7, 1'b0);
      pred_m("byp_chain1", 32'h1C, 2'd1, 8'd7);
      tick();
      pred_m("byp_chain2", 32'h1C, 2'd0, 8'd7);
      tick();
      check("bimodal_ghr", m_ghr, 0);

      // Gshare history and indexing.
      upd_g(8'h40, 1'b1);
      tick();
      upd_g(8'h40, 1'b1);
      tick();
      tick();
      check("gshare_ghr_3", g_ghr, 8'h03);
      pred_g("gshare_idx6", 32'h14, 2'd1, 8'h06);
      tick();
      upd_g(8'h40, 1'b1);
      tick();
      pred_g("gshare_old_ghr", 32'h14, 2'd1, 8'h06);
      tick();
      check("gshare_ghr_7", g_ghr, 8'h07);
      pred_g("gshare_idx2", 32'h14, 2'd1, 8'h02);
      tick();

      check("m_queue_drained", m_q.size(), 0);
      check("g_queue_drained", g_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
